seq_pattern_matcher: RTL and testbench

SEQ_PATTERN_MATCHER -- requirements
Module: seq_pattern_matcher

---
 rtl/seq_pattern_matcher_if.sv | 28 ++
 rtl/seq_pattern_matcher.sv | 120 ++++++++++++
 tb/tb_seq_pattern_matcher.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_matcher_if.sv
// Serial-bit, pattern-programming and match-reporting signals of the pattern matcher.
// The testbench drives the master side; the matcher uses the slave side.
interface seq_pattern_matcher_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             overlap_mode;
  logic [PAT_W-1:0] pattern_in;
  logic [PAT_W-1:0] mask_in;
  logic             pattern_load;
  logic             count_clear;
  logic             match_pulse;
  logic [CNT_W-1:0] pattern_count;
  logic             count_saturated;
  logic             armed;

  modport master (
    output bit_in, bit_valid, overlap_mode, pattern_in, mask_in, pattern_load, count_clear,
    input  match_pulse, pattern_count, count_saturated, armed
  );

  modport slave (
    input  bit_in, bit_valid, overlap_mode, pattern_in, mask_in, pattern_load, count_clear,
    output match_pulse, pattern_count, count_saturated, armed
  );
endinterface

// File: rtl/seq_pattern_matcher.sv
// Serial bit-pattern matcher: masked compare over a PAT_W-bit shift history with
// overlapping / non-overlapping counting and a saturating, clearable match counter.
module seq_pattern_matcher #(
  parameter int               PAT_W           = 4,
  parameter int               CNT_W           = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PATTERN = PAT_W'(4'b1011)
) (
  input  logic                clock_100Mhz,
  input  logic                reset,
  seq_pattern_matcher_if.slave bus
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_t;

  state_t            state_p0, state_nxt;
  logic [PAT_W-1:0]  shift_p0, shift_nxt;
  logic [PAT_W-1:0]  pattern_p0, pattern_nxt;
  logic [PAT_W-1:0]  mask_p0, mask_nxt;
  logic [FILL_W-1:0] fill_p0, fill_nxt;
  logic [CNT_W-1:0]  count_p1, count_nxt;
  logic              sat_p1, sat_nxt;
  logic              match_p1;

  logic              accept;
  logic              qualified;
  logic              hit;
  logic              match;
  logic [PAT_W-1:0]  shift_cand;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_W'(1);
  endfunction

  // An all-zero mask would trivially match everything, so it disables detection.
  function automatic logic masked_hit(input logic [PAT_W-1:0] value,
                                      input logic [PAT_W-1:0] pat,
                                      input logic [PAT_W-1:0] mask);
    return (mask != '0) && (((value ^ pat) & mask) == '0);
  endfunction

  always_comb begin
    accept      = bus.bit_valid & ~bus.pattern_load;
    shift_cand  = {shift_p0[PAT_W-2:0], bus.bit_in};
    hit         = masked_hit(shift_cand, pattern_p0, mask_p0);
    // The bit that completes the fill already counts as a full window.
    qualified   = (state_p0 == ARMED) || (fill_p0 == FILL_LAST);
    match       = accept & hit & qualified;

    state_nxt   = state_p0;
    shift_nxt   = shift_p0;
    fill_nxt    = fill_p0;
    pattern_nxt = pattern_p0;
    mask_nxt    = mask_p0;
    count_nxt   = count_p1;
    sat_nxt     = sat_p1;

    if (bus.pattern_load) begin
      pattern_nxt = bus.pattern_in;
      mask_nxt    = bus.mask_in;
      shift_nxt   = '0;
      fill_nxt    = '0;
      state_nxt   = FILL;
    end else if (accept) begin
      if (match && !bus.overlap_mode) begin
        shift_nxt = '0;
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        shift_nxt = shift_cand;
        if (state_p0 == FILL) begin
          fill_nxt = fill_p0 + FILL_W'(1);
          if (fill_p0 == FILL_LAST) begin
            state_nxt = ARMED;
          end
        end
      end
    end

    if (bus.count_clear) begin
      count_nxt = '0;
      sat_nxt   = 1'b0;
    end else if (match) begin
      count_nxt = sat_inc(count_p1);
      sat_nxt   = sat_p1 | (sat_inc(count_p1) == CNT_MAX);
    end
  end

  // Stage p0 -> p1: history/FSM update and registered match reporting.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_p0   <= FILL;
      shift_p0   <= '0;
      fill_p0    <= '0;
      pattern_p0 <= DEFAULT_PATTERN;
      mask_p0    <= '1;
      count_p1   <= '0;
      sat_p1     <= 1'b0;
      match_p1   <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      shift_p0   <= shift_nxt;
      fill_p0    <= fill_nxt;
      pattern_p0 <= pattern_nxt;
      mask_p0    <= mask_nxt;
      count_p1   <= count_nxt;
      sat_p1     <= sat_nxt;
      match_p1   <= match;
    end
  end

  assign bus.match_pulse     = match_p1;
  assign bus.pattern_count   = count_p1;
  assign bus.count_saturated = sat_p1;
  assign bus.armed           = (state_p0 == ARMED);

endmodule

// File: tb/tb_seq_pattern_matcher.sv
// Bench for seq_pattern_matcher: directed scenarios plus a randomized run against a
// queue-based history model; a CNT_W=2 copy shares the stimulus to exercise saturation.
module tb_seq_pattern_matcher;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_pattern_matcher_if #(.PAT_W(4), .CNT_W(8)) bus_a ();
  seq_pattern_matcher_if #(.PAT_W(4), .CNT_W(2)) bus_b ();

  assign bus_b.bit_in       = bus_a.bit_in;
  assign bus_b.bit_valid    = bus_a.bit_valid;
  assign bus_b.overlap_mode = bus_a.overlap_mode;
  assign bus_b.pattern_in   = bus_a.pattern_in;
  assign bus_b.mask_in      = bus_a.mask_in;
  assign bus_b.pattern_load = bus_a.pattern_load;
  assign bus_b.count_clear  = bus_a.count_clear;

  seq_pattern_matcher #(.PAT_W(4), .CNT_W(8), .DEFAULT_PATTERN(4'b1011)) dut_a (
    .clock_100Mhz(clk), .reset(rst), .bus(bus_a.slave));

  seq_pattern_matcher #(.PAT_W(4), .CNT_W(2), .DEFAULT_PATTERN(4'b1011)) dut_b (
    .clock_100Mhz(clk), .reset(rst), .bus(bus_b.slave));

  // Reference model: the accepted bits since the last reset/flush/load.
  bit         hist[$];
  logic [3:0] m_pat;
  logic [3:0] m_mask;
  int         c_a, c_b;
  logic       s_a, s_b, e_pulse, e_armed;

  task automatic model_step(input logic r, v, b, ovl, ld, input logic [3:0] pin, min,
                            input logic clr);
    logic       m;
    logic [3:0] win;
    m = 1'b0;
    if (r) begin
      hist.delete();
      m_pat = 4'b1011; m_mask = 4'hF;
      c_a = 0; c_b = 0; s_a = 1'b0; s_b = 1'b0;
    end else begin
      if (ld) begin
        m_pat = pin; m_mask = min;
        hist.delete();
      end else if (v) begin
        hist.push_back(b);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4) begin
          win = 4'b0;
          foreach (hist[i]) win = {win[2:0], hist[i]};
          m = (m_mask != 4'b0) && (((win ^ m_pat) & m_mask) == 4'b0);
        end
        if (m && !ovl) hist.delete();
      end
      if (clr) begin
        c_a = 0; c_b = 0; s_a = 1'b0; s_b = 1'b0;
      end else if (m) begin
        if (c_a < 255) c_a++;
        if (c_a == 255) s_a = 1'b1;
        if (c_b < 3) c_b++;
        if (c_b == 3) s_b = 1'b1;
      end
    end
    e_pulse = m;
    e_armed = (hist.size() == 4);
  endtask

  task automatic cycle(input logic r, v, b, ovl, ld, input logic [3:0] pin, min,
                       input logic clr);
    rst                = r;
    bus_a.bit_valid    = v;
    bus_a.bit_in       = b;
    bus_a.overlap_mode = ovl;
    bus_a.pattern_load = ld;
    bus_a.pattern_in   = pin;
    bus_a.mask_in      = min;
    bus_a.count_clear  = clr;
    @(posedge clk);
    model_step(r, v, b, ovl, ld, pin, min, clr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic send_bit(input logic b, input logic ovl);
    cycle(1'b0, 1'b1, b, ovl, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic load(input logic [3:0] pin, input logic [3:0] min);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, pin, min, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({bus_a.match_pulse, bus_a.pattern_count, bus_a.count_saturated, bus_a.armed} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_a: got %b want all zero",
               {bus_a.match_pulse, bus_a.pattern_count, bus_a.count_saturated, bus_a.armed});
    end
    n_vec++;
    if ({bus_b.match_pulse, bus_b.pattern_count, bus_b.count_saturated, bus_b.armed} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_b: got %b want all zero",
               {bus_b.match_pulse, bus_b.pattern_count, bus_b.count_saturated, bus_b.armed});
    end
  endtask

  task automatic test_overlap();
    logic [6:0] seq    = 7'b1011011;
    logic [6:0] exp_ov = 7'b0001001;
    logic [6:0] exp_no = 7'b0001000;
    for (int mode = 1; mode >= 0; mode--) begin
      do_reset();
      for (int i = 6; i >= 0; i--) begin
        send_bit(seq[i], mode[0]);
        n_vec++;
        if (bus_a.match_pulse !== (mode == 1 ? exp_ov[i] : exp_no[i])) begin
          n_err++;
          $display("FAIL overlap%0d_pulse bit%0d: got %b want %b", mode, 7 - i,
                   bus_a.match_pulse, (mode == 1 ? exp_ov[i] : exp_no[i]));
        end
      end
      n_vec++;
      if (bus_a.pattern_count !== (mode == 1 ? 8'd2 : 8'd1)) begin
        n_err++;
        $display("FAIL overlap%0d_count: got %0d want %0d", mode, bus_a.pattern_count,
                 (mode == 1 ? 2 : 1));
      end
    end
  endtask

  task automatic test_load();
    logic [5:0] seq = 6'b110011;
    do_reset();
    load(4'b0011, 4'b1111);
    for (int i = 5; i >= 0; i--) begin
      send_bit(seq[i], 1'b1);
      if (i == 4) begin
        n_vec++;
        if ({bus_a.match_pulse, bus_a.armed} !== 2'b00) begin
          n_err++;
          $display("FAIL load_partial: got pulse,armed=%b want 00", {bus_a.match_pulse, bus_a.armed});
        end
      end
    end
    n_vec++;
    if ({bus_a.match_pulse, bus_a.pattern_count} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL load_match: got pulse=%b count=%0d want 1/1", bus_a.match_pulse, bus_a.pattern_count);
    end
  endtask

  task automatic test_mask();
    do_reset();
    load(4'b1001, 4'b1001);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    n_vec++;
    if ({bus_a.match_pulse, bus_a.pattern_count} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL mask_match: got pulse=%b count=%0d want 1/1", bus_a.match_pulse, bus_a.pattern_count);
    end
    send_bit(1'b0, 1'b1);
    n_vec++;
    if ({bus_a.match_pulse, bus_a.pattern_count} !== {1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL mask_nomatch: got pulse=%b count=%0d want 0/1", bus_a.match_pulse, bus_a.pattern_count);
    end
    load(4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      send_bit(1'($urandom_range(0, 1)), 1'b1);
      n_vec++;
      if (bus_a.match_pulse !== 1'b0) begin
        n_err++;
        $display("FAIL zero_mask bit%0d: got pulse=%b want 0", i, bus_a.match_pulse);
      end
    end
  endtask

  task automatic test_saturate();
    logic [15:0] seq = 16'b1011011011011011;
    int pulses = 0;
    do_reset();
    for (int i = 15; i >= 0; i--) begin
      send_bit(seq[i], 1'b1);
      if (bus_b.match_pulse === 1'b1) pulses++;
      if (i == 6) begin
        n_vec++;
        if ({bus_b.pattern_count, bus_b.count_saturated} !== 3'b111) begin
          n_err++;
          $display("FAIL sat_third: got count=%0d sat=%b want 3/1", bus_b.pattern_count, bus_b.count_saturated);
        end
      end
    end
    n_vec++;
    if ({bus_b.pattern_count, bus_b.count_saturated} !== 3'b111 || pulses != 5) begin
      n_err++;
      $display("FAIL sat_fifth: got count=%0d sat=%b pulses=%0d want 3/1/5",
               bus_b.pattern_count, bus_b.count_saturated, pulses);
    end
    n_vec++;
    if ({bus_a.pattern_count, bus_a.count_saturated} !== {8'd5, 1'b0}) begin
      n_err++;
      $display("FAIL sat_wide: got count=%0d sat=%b want 5/0", bus_a.pattern_count, bus_a.count_saturated);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    n_vec++;
    if ({bus_b.pattern_count, bus_b.count_saturated, bus_b.armed} !== 4'b0001) begin
      n_err++;
      $display("FAIL sat_clear: got count=%0d sat=%b armed=%b want 0/0/1",
               bus_b.pattern_count, bus_b.count_saturated, bus_b.armed);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    n_vec++;
    if ({bus_a.match_pulse, bus_a.pattern_count} !== {1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL clear_win: got pulse=%b count=%0d want 1/0", bus_a.match_pulse, bus_a.pattern_count);
    end
    do_reset();
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b1111, 1'b0);
    n_vec++;
    if ({bus_a.match_pulse, bus_a.armed} !== 2'b00) begin
      n_err++;
      $display("FAIL load_valid: got pulse,armed=%b want 00", {bus_a.match_pulse, bus_a.armed});
    end
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    n_vec++;
    if ({bus_a.match_pulse, bus_a.armed, bus_a.pattern_count} !== {2'b00, 8'd0}) begin
      n_err++;
      $display("FAIL load_fill: got pulse=%b armed=%b count=%0d want 0/0/0",
               bus_a.match_pulse, bus_a.armed, bus_a.pattern_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(4'b0110, 4'b1111);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    do_reset();
    send_bit(1'b1, 1'b1);
    n_vec++;
    if ({bus_a.match_pulse, bus_a.pattern_count, bus_a.armed} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_mid: got pulse=%b count=%0d armed=%b want 0/0/0",
               bus_a.match_pulse, bus_a.pattern_count, bus_a.armed);
    end
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    n_vec++;
    if ({bus_a.match_pulse, bus_a.pattern_count} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL reset_pattern: got pulse=%b count=%0d want 1/1", bus_a.match_pulse, bus_a.pattern_count);
    end
  endtask

  task automatic test_random();
    logic ovl = 1'b1;
    logic v, b, ld, clr;
    logic [3:0] pin, min;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) ovl = ~ovl;
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 59) == 0);
      pin = 4'($urandom_range(0, 15));
      min = 4'($urandom_range(0, 15));
      cycle(1'b0, v, b, ovl, ld, pin, min, clr);
      n_vec++;
      if ({bus_a.match_pulse, bus_a.pattern_count, bus_a.count_saturated, bus_a.armed}
          !== {e_pulse, 8'(c_a), s_a, e_armed}) begin
        n_err++;
        $display("FAIL random_a cyc%0d: got %b want %b", i,
                 {bus_a.match_pulse, bus_a.pattern_count, bus_a.count_saturated, bus_a.armed},
                 {e_pulse, 8'(c_a), s_a, e_armed});
      end
      n_vec++;
      if ({bus_b.match_pulse, bus_b.pattern_count, bus_b.count_saturated, bus_b.armed}
          !== {e_pulse, 2'(c_b), s_b, e_armed}) begin
        n_err++;
        $display("FAIL random_b cyc%0d: got %b want %b", i,
                 {bus_b.match_pulse, bus_b.pattern_count, bus_b.count_saturated, bus_b.armed},
                 {e_pulse, 2'(c_b), s_b, e_armed});
      end
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus_a.bit_in       = 1'b0;
    bus_a.bit_valid    = 1'b0;
    bus_a.overlap_mode = 1'b0;
    bus_a.pattern_in   = 4'h0;
    bus_a.mask_in      = 4'h0;
    bus_a.pattern_load = 1'b0;
    bus_a.count_clear  = 1'b0;
    @(negedge clk);
    test_reset();
    test_overlap();
    test_load();
    test_mask();
    test_saturate();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
